smac_seq_ctrl: RTL

Sequencer for one SubMAC lane group. Accepts an accumulate command (precision lane plus beat count) and streams operand pairs into the SubMAC. It drives ce/sclr/select_precision/active_chain, drains the DSP pipeline, then returns the lane result zero-extended to 64 bits through a valid/ready handshake. It sits between the tile scheduler and smac.

---
 rtl/smac_seq_ctrl_pkg.sv | 22 ++
 rtl/smac_lane_extract.sv | 23 ++
 rtl/smac_seq_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/smac_seq_ctrl_pkg.sv
// Shared definitions for the SubMAC sequencer: one-hot precision codes,
// FSM state encoding and a one-hot legality helper.
package smac_seq_ctrl_pkg;

    localparam logic [3:0] PREC_I8_L0 = 4'b0001;
    localparam logic [3:0] PREC_I8_L1 = 4'b0010;
    localparam logic [3:0] PREC_I16   = 4'b0100;
    localparam logic [3:0] PREC_I32   = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/smac_lane_extract.sv
// Selects the active precision lane out of the SubMAC result word and
// zero-extends it to 64 bits.
module smac_lane_extract
    import smac_seq_ctrl_pkg::*;
(
    input  logic [3:0]  prec,
    input  logic [63:0] word,
    output logic [63:0] lane
);

    // Lane multiplexer; an illegal precision code yields zero
    always_comb begin
        lane = 64'd0;
        case (prec)
            PREC_I8_L0: lane = {56'd0, word[7:0]};
            PREC_I8_L1: lane = {56'd0, word[15:8]};
            PREC_I16:   lane = {48'd0, word[31:16]};
            PREC_I32:   lane = {32'd0, word[63:32]};
            default:    lane = 64'd0;
        endcase
    end

endmodule

// File: rtl/smac_seq_ctrl.sv
// Sequencer for one SubMAC lane group: clear, stream operands, drain, return result.
// Optional performance counters are enabled by defining SMAC_SEQ_CTRL_PERF_EN.
module smac_seq_ctrl
    import smac_seq_ctrl_pkg::*;
#(
    parameter int DSP_LAT = 3,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_prec,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_err,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic [63:0]      in_weight,
    output logic [63:0]      smac_data,
    output logic [63:0]      smac_weight,
    output logic             smac_ce,
    output logic             smac_sclr,
    output logic [3:0]       smac_prec,
    output logic             smac_chain,
    input  logic [63:0]      smac_res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic             busy
`ifdef SMAC_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_stall,
    output logic [31:0]      perf_active
`endif
);

    localparam int DRN_W = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DSP_LAT - 1);

    seq_state_e       state_r, state_next_s;
    logic [3:0]       prec_r, prec_next_s;
    logic [LEN_W-1:0] len_r, beat_cnt_r;
    logic [DRN_W-1:0] drain_cnt_r;
    logic             cmd_ready_r, cmd_err_r, smac_sclr_r, smac_chain_r;
    logic             res_valid_r, busy_r;
    logic [3:0]       smac_prec_r;
    logic [63:0]      res_data_r, lane_s;
    logic             accept_s, reject_s, abort_s, beat_s, last_beat_s;
    logic             drain_last_s, in_seq_s, in_chain_s;

    assign accept_s     = (state_r == ST_IDLE) && cmd_valid && is_onehot4(cmd_prec);
    assign reject_s     = (state_r == ST_IDLE) && cmd_valid && !is_onehot4(cmd_prec);
    assign abort_s      = abort && (state_r != ST_IDLE);
    assign beat_s       = (state_r == ST_RUN) && in_valid && !abort_s;
    assign last_beat_s  = beat_s && (beat_cnt_r == (len_r - {{(LEN_W-1){1'b0}}, 1'b1}));
    assign drain_last_s = (state_r == ST_DRAIN) && (drain_cnt_r == {DRN_W{1'b0}});
    assign prec_next_s  = accept_s ? cmd_prec : prec_r;
    assign in_seq_s     = (state_next_s == ST_CLEAR) || (state_next_s == ST_RUN) ||
                          (state_next_s == ST_DRAIN);
    assign in_chain_s   = ((state_next_s == ST_RUN) || (state_next_s == ST_DRAIN)) &&
                          (prec_next_s == PREC_I32);

    // Operand path is combinational so a stalled beat never reaches the pipeline
    assign in_ready    = (state_r == ST_RUN) && !abort_s;
    assign smac_ce     = beat_s || ((state_r == ST_DRAIN) && !abort_s);
    assign smac_data   = (state_r == ST_RUN) ? in_data   : 64'd0;
    assign smac_weight = (state_r == ST_RUN) ? in_weight : 64'd0;

    smac_lane_extract u_lane (
        .prec (prec_r),
        .word (smac_res),
        .lane (lane_s)
    );

    // Next-state logic; abort overrides every normal transition
    always_comb begin
        state_next_s = state_r;
        if (abort_s) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  if (accept_s) state_next_s = ST_CLEAR; else state_next_s = ST_IDLE;
                ST_CLEAR: if (len_r != {LEN_W{1'b0}}) state_next_s = ST_RUN; else state_next_s = ST_DONE;
                ST_RUN:   if (last_beat_s) state_next_s = ST_DRAIN; else state_next_s = ST_RUN;
                ST_DRAIN: if (drain_last_s) state_next_s = ST_DONE; else state_next_s = ST_DRAIN;
                ST_DONE:  if (res_ready) state_next_s = ST_IDLE; else state_next_s = ST_DONE;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // State, command latches, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            prec_r       <= 4'b0000;
            len_r        <= {LEN_W{1'b0}};
            beat_cnt_r   <= {LEN_W{1'b0}};
            drain_cnt_r  <= {DRN_W{1'b0}};
            cmd_ready_r  <= 1'b1;
            cmd_err_r    <= 1'b0;
            smac_sclr_r  <= 1'b0;
            smac_prec_r  <= 4'b0000;
            smac_chain_r <= 1'b0;
            res_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            res_data_r   <= 64'd0;
        end else begin
            state_r <= state_next_s;
            prec_r  <= prec_next_s;
            if (accept_s) begin
                len_r      <= cmd_len;
                beat_cnt_r <= {LEN_W{1'b0}};
            end else if (beat_s) begin
                beat_cnt_r <= beat_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
            end
            if (last_beat_s) begin
                drain_cnt_r <= DRAIN_LOAD;
            end else if ((state_r == ST_DRAIN) && !drain_last_s) begin
                drain_cnt_r <= drain_cnt_r - {{(DRN_W-1){1'b0}}, 1'b1};
            end
            // Outputs are registered from the state being entered, so they line up with it
            cmd_ready_r  <= (state_next_s == ST_IDLE);
            cmd_err_r    <= reject_s;
            smac_sclr_r  <= (state_next_s == ST_CLEAR) || abort_s;
            smac_prec_r  <= in_seq_s ? prec_next_s : 4'b0000;
            smac_chain_r <= in_chain_s;
            res_valid_r  <= (state_next_s == ST_DONE);
            busy_r       <= (state_next_s != ST_IDLE);
            if ((state_r == ST_CLEAR) && (len_r == {LEN_W{1'b0}}) && !abort_s) begin
                res_data_r <= 64'd0;
            end else if (drain_last_s && !abort_s) begin
                res_data_r <= lane_s;
            end
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign cmd_err    = cmd_err_r;
    assign smac_sclr  = smac_sclr_r;
    assign smac_prec  = smac_prec_r;
    assign smac_chain = smac_chain_r;
    assign res_valid  = res_valid_r;
    assign res_data   = res_data_r;
    assign busy       = busy_r;

`ifdef SMAC_SEQ_CTRL_PERF_EN
    logic [31:0] perf_stall_r, perf_active_r;

    // Saturating stall and activity counters, restarted by each accepted command
    always_ff @(posedge clk) begin
        if (!resetn || accept_s) begin
            perf_stall_r  <= 32'd0;
            perf_active_r <= 32'd0;
        end else begin
            if ((state_r == ST_RUN) && !in_valid && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
            if (smac_ce && (perf_active_r != 32'hFFFF_FFFF)) begin
                perf_active_r <= perf_active_r + 32'd1;
            end
        end
    end

    assign perf_stall  = perf_stall_r;
    assign perf_active = perf_active_r;
`endif

endmodule
